switch_pio_poll_ctrl: RTL and testbench

//  Avalon-MM master that periodically reads the switch PIO (data register, offset 0), debounces
//  the 18 switch bits over consecutive samples and queues change events for the CPU or consumer.

---
 rtl/sw_poll_pkg.sv | 14 +
 rtl/switch_event_fifo.sv | 57 +++++
 rtl/switch_pio_poll_ctrl.sv | 146 ++++++++++++++
 tb/tb_switch_pio_poll_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_poll_pkg.sv
// Shared definitions for the switch PIO poller: FSM state encodings and event entry sizing.
package sw_poll_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_EVAL = 2'd3;

  // An event carries the new debounced value followed by the toggled-bit mask.
  function automatic int ev_entry_width(input int sw_width);
    return 2 * sw_width;
  endfunction

endpackage

// File: rtl/switch_event_fifo.sv
// Synchronous first-word-fall-through FIFO holding switch change events.
module switch_event_fifo
  import sw_poll_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  // DEPTH is a power of two >= 2; the extra pointer bit tells full from empty.
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/switch_pio_poll_ctrl.sv
// Avalon-MM master that polls the switch PIO, debounces the switch word and queues change events.
module switch_pio_poll_ctrl
  import sw_poll_pkg::*;
#(
  parameter int         SW_WIDTH     = 18,
  parameter int         POLL_DIV     = 50000,
  parameter int         DEBOUNCE_CNT = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [1:0] PIO_ADDR     = 2'd0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic [1:0]          avm_address,
  output logic                avm_read,
  input  logic                avm_waitrequest,
  input  logic [31:0]         avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [SW_WIDTH-1:0] ev_data,
  output logic [SW_WIDTH-1:0] ev_changed,
  output logic [SW_WIDTH-1:0] stable_sw,
  output logic                irq,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int EW = ev_entry_width(SW_WIDTH);
  localparam int TW = $clog2(POLL_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CNT);

  logic [TW-1:0]       timer_q, timer_d;
  logic [1:0]          state_q, state_d;
  logic                pending_q, pending_d;
  logic [SW_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW_WIDTH-1:0] stable_q, stable_d;
  logic                ovf_q, ovf_d;
  logic [SW_WIDTH-1:0] sample_q;
  logic                tick;
  logic                push;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head_data;
  logic                fifo_full;
  logic                fifo_empty;

  if (SW_WIDTH < 32) begin : g_unused_rd
    logic unused_rd;
    assign unused_rd = ^avm_readdata[31:SW_WIDTH];
  end

  assign tick    = enable && (timer_q == TIMER_LAST);
  assign timer_d = (!enable || tick) ? '0 : timer_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    push      = 1'b0;
    // A tick that lands mid-transaction is remembered once; more are dropped.
    if (tick && state_q != ST_IDLE) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if ((tick || pending_q) && enable) begin
          state_d   = ST_REQ;
          pending_d = 1'b0;
        end
      end
      ST_REQ:  if (!avm_waitrequest) state_d = ST_WAIT;
      ST_WAIT: if (avm_readdatavalid) state_d = ST_EVAL;
      ST_EVAL: begin
        if (sample_q == cand_q) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cand_d = sample_q;
          cnt_d  = CW'(1);
        end
        if (cnt_d == CNT_MAX && cand_d != stable_q) begin
          stable_d = cand_d;
          push     = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_data = {cand_d, cand_d ^ stable_q};

  // Set beats clear; a full FIFO that is popped this cycle takes the push instead.
  assign ovf_d = (push && fifo_full && !ev_ready) ? 1'b1 :
                 ovf_clr                          ? 1'b0 : ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_WAIT && avm_readdatavalid) sample_q <= avm_readdata[SW_WIDTH-1:0];
  end

  switch_event_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_data_i(push_data),
    .full_o     (fifo_full),
    .pop_i      (ev_ready),
    .pop_data_o (head_data),
    .empty_o    (fifo_empty)
  );

  assign avm_address = PIO_ADDR;
  assign avm_read    = (state_q == ST_REQ);
  assign ev_valid    = !fifo_empty;
  assign irq         = !fifo_empty;
  assign ev_data     = head_data[EW-1:SW_WIDTH];
  assign ev_changed  = head_data[SW_WIDTH-1:0];
  assign stable_sw   = stable_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_switch_pio_poll_ctrl.sv
// Bench for switch_pio_poll_ctrl: PIO slave responder, event-level model and directed scenarios.
module tb_switch_pio_poll_ctrl;

  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [31:0]   avm_readdata;
  logic          avm_readdatavalid;
  logic          ev_valid;
  logic          ev_ready;
  logic [W-1:0]  ev_data;
  logic [W-1:0]  ev_changed;
  logic [W-1:0]  stable_sw;
  logic          irq;
  logic          ovf;
  logic          ovf_clr;

  switch_pio_poll_ctrl #(
    .SW_WIDTH(W), .POLL_DIV(10), .DEBOUNCE_CNT(3), .FIFO_DEPTH(4), .PIO_ADDR(2'd0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_changed(ev_changed),
    .stable_sw(stable_sw), .irq(irq), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Switch inputs seen by the slave, slave behaviour knobs and bookkeeping.
  logic [W-1:0] in_port;
  int lat;
  int stray_req, stray_done;
  int cyc, acc_cnt, acc_cyc, samp_cnt;

  // Event-level model: last three samples, accepted value, event queue, overflow flag.
  logic [W-1:0]     hist[$];
  logic [2*W-1:0]   mq[$];
  logic [W-1:0]     m_stable;
  logic             m_ovf;

  task automatic model_reset();
    hist.delete();
    mq.delete();
    m_stable = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_sample(input logic [W-1:0] s, output bit set);
    set = 1'b0;
    hist.push_back(s);
    if (hist.size() > 3) void'(hist.pop_front());
    if (hist.size() == 3 && hist[0] == s && hist[1] == s && s != m_stable) begin
      if (mq.size() < 4) mq.push_back({s, s ^ m_stable});
      else set = 1'b1;
      m_stable = s;
    end
  endtask

  // PIO slave with configurable read latency, plus the model's clock-edge updates.
  initial begin
    bit accept_next, pop_next, clr_next, set;
    int resp_cd, upd_cd;
    logic [W-1:0] upd_sample;
    accept_next = 0; pop_next = 0; clr_next = 0;
    resp_cd = 0; upd_cd = 0; upd_sample = '0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    cyc = 0; acc_cnt = 0; acc_cyc = 0; samp_cnt = 0; stray_done = 0;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      avm_readdatavalid = 1'b0;
      if (!reset_n) begin
        model_reset();
        resp_cd = 0;
        upd_cd = 0;
      end else begin
        if (pop_next && mq.size() > 0) void'(mq.pop_front());
        set = 1'b0;
        if (upd_cd > 0) begin
          upd_cd--;
          if (upd_cd == 0) model_sample(upd_sample, set);
        end
        if (set) m_ovf = 1'b1;
        else if (clr_next) m_ovf = 1'b0;
        if (accept_next) begin
          acc_cnt++;
          acc_cyc = cyc;
          resp_cd = lat;
        end
        if (resp_cd > 0) begin
          resp_cd--;
          if (resp_cd == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = {14'h3A5C, in_port};
            upd_sample = in_port;
            upd_cd = 2;
            samp_cnt++;
          end
        end else if (stray_req != stray_done) begin
          stray_done = stray_req;
          avm_readdatavalid = 1'b1;
          avm_readdata = 32'hFFFF_FFFF;
        end
      end
      @(negedge clk);
      accept_next = reset_n && avm_read && !avm_waitrequest;
      pop_next = ev_ready;
      clr_next = ovf_clr;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      check("addr", {30'd0, avm_address}, 32'd0);
      check("ev_valid", {31'd0, ev_valid}, {31'd0, mq.size() > 0});
      check("irq", {31'd0, irq}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        check("ev_data", {14'd0, ev_data}, {14'd0, mq[0][2*W-1:W]});
        check("ev_changed", {14'd0, ev_changed}, {14'd0, mq[0][W-1:0]});
      end
      check("stable_sw", {14'd0, stable_sw}, {14'd0, m_stable});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    end else begin
      check("rst_read", {31'd0, avm_read}, 32'd0);
      check("rst_valid", {31'd0, ev_valid}, 32'd0);
      check("rst_stable", {14'd0, stable_sw}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_samples(input int n);
    int target;
    target = samp_cnt + n;
    for (int k = 0; k < 400 && samp_cnt < target; k++) step();
    check("wait_samples", samp_cnt, target);
  endtask

  task automatic wait_read_high();
    int k;
    k = 0;
    while (!avm_read && k < 40) begin
      step();
      k++;
    end
    check("wait_read", {31'd0, avm_read}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] vals [6];
    int a0, c1, hi, n;
    vals[0] = 18'h11; vals[1] = 18'h22; vals[2] = 18'h33;
    vals[3] = 18'h44; vals[4] = 18'h55; vals[5] = 18'h66;
    reset_n = 1'b0; enable = 1'b0; avm_waitrequest = 1'b0; ev_ready = 1'b0;
    ovf_clr = 1'b0; in_port = '0; lat = 1; stray_req = 0;
    repeat (3) step();
    check("reset_read", {31'd0, avm_read}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    in_port = 18'h00005;

    // Held value accepted on the third poll
    wait_samples(2);
    repeat (3) step();
    check("t1_no_early_event", {31'd0, ev_valid}, 32'd0);
    wait_samples(1);
    repeat (3) step();
    check("t1_irq", {31'd0, irq}, 32'd1);
    check("t1_data", {14'd0, ev_data}, 32'h5);
    check("t1_changed", {14'd0, ev_changed}, 32'h5);
    check("t1_stable", {14'd0, stable_sw}, 32'h5);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    step();
    check("t1_irq_popped", {31'd0, irq}, 32'd0);
    wait_samples(3);
    repeat (3) step();
    check("t1_no_more", {31'd0, ev_valid}, 32'd0);

    // Bounce 1,0,1,1,1 from a fresh stable 0
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    in_port = 18'h1;
    wait_samples(1);
    in_port = 18'h0;
    wait_samples(1);
    in_port = 18'h1;
    wait_samples(2);
    repeat (3) step();
    check("t2_no_event_4th", {31'd0, ev_valid}, 32'd0);
    wait_samples(1);
    repeat (3) step();
    check("t2_valid", {31'd0, ev_valid}, 32'd1);
    check("t2_data", {14'd0, ev_data}, 32'h1);
    check("t2_changed", {14'd0, ev_changed}, 32'h1);
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;

    // Stalled request, then a tick landing in a long WAIT
    avm_waitrequest = 1'b1;
    wait_read_high();
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_read_held", {31'd0, avm_read}, 32'd1);
      check("t3_addr_held", {30'd0, avm_address}, 32'd0);
    end
    check("t3_no_accept", acc_cnt, a0);
    avm_waitrequest = 1'b0;
    wait_samples(1);
    check("t3_one_read", acc_cnt, a0 + 1);
    lat = 9;
    a0 = acc_cnt;
    for (int k = 0; k < 40 && acc_cnt == a0; k++) step();
    lat = 1;
    c1 = acc_cyc;
    a0 = acc_cnt;
    for (int k = 0; k < 40 && acc_cnt == a0; k++) step();
    check("t3_b2b_gap", acc_cyc - c1, 32'd12);

    // Overflow with the consumer stalled
    for (int i = 0; i < 5; i++) begin
      in_port = vals[i];
      wait_samples(3);
    end
    repeat (3) step();
    check("t4_ovf", {31'd0, ovf}, 32'd1);
    check("t4_stable", {14'd0, stable_sw}, 32'h55);
    check("t4_head", {14'd0, ev_data}, 32'h11);
    check("t4_head_chg", {14'd0, ev_changed}, 32'h10);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    step();
    check("t4_ovf_clr", {31'd0, ovf}, 32'd0);
    in_port = vals[5];
    wait_samples(3);
    step();
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    check("t4_pushpop_noovf", {31'd0, ovf}, 32'd0);
    check("t4_stable6", {14'd0, stable_sw}, 32'h66);
    check("t4_head2", {14'd0, ev_data}, 32'h22);
    check("t4_head2_chg", {14'd0, ev_changed}, 32'h33);
    ev_ready = 1'b1;
    repeat (4) step();
    ev_ready = 1'b0;
    check("t4_drained", {31'd0, ev_valid}, 32'd0);

    // Asynchronous reset during WAIT, then a stray readdatavalid
    wait_read_high();
    step();
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_read", {31'd0, avm_read}, 32'd0);
    check("t5_stable", {14'd0, stable_sw}, 32'd0);
    check("t5_irq", {31'd0, irq}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    stray_req++;
    repeat (4) step();
    check("t5_stray_stable", {14'd0, stable_sw}, 32'd0);
    check("t5_stray_valid", {31'd0, ev_valid}, 32'd0);

    // Disabled polling, then re-enable latency
    enable = 1'b0;
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (avm_read) hi++;
    end
    check("t6_no_reads", hi, 32'd0);
    enable = 1'b1;
    n = 0;
    while (!avm_read && n < 40) begin
      step();
      n++;
    end
    check("t6_first_read", n, 32'd10);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
